// File: rtl/voice_allocator_if.sv
// Event handshake bundle for the voice allocator: one note-on/note-off event
// offered per valid/ready transfer.
interface voice_allocator_if #(
    parameter int NOTE_W = 12,
    parameter int DUR_W  = 16,
    parameter int VEL_W  = 8
);
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_release;
    logic [NOTE_W-1:0] ev_note;
    logic [DUR_W-1:0]  ev_dur_ms;
    logic [VEL_W-1:0]  ev_vel;

    modport master (
        output ev_valid, ev_release, ev_note, ev_dur_ms, ev_vel,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_release, ev_note, ev_dur_ms, ev_vel,
        output ev_ready
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns note events to voice slots, times them
// out on a 1 kHz tick derived from the sample strobe, and steals or drops when full.
module voice_allocator #(
    parameter int NUM_VOICES  = 4,
    parameter int NOTE_W      = 12,
    parameter int DUR_W       = 16,
    parameter int VEL_W       = 8,
    parameter int SAMPLE_RATE = 44100,
    parameter int STEAL_MODE  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_sample_tick,
    voice_allocator_if.slave             ev_if,
    output logic [NUM_VOICES-1:0]        o_voice_active,
    output logic [NUM_VOICES-1:0]        o_voice_start,
    output logic [NUM_VOICES-1:0]        o_voice_end,
    output logic [NUM_VOICES*NOTE_W-1:0] o_voice_note,
    output logic [NUM_VOICES*VEL_W-1:0]  o_voice_vel,
    output logic                         o_steal_pulse,
    output logic [15:0]                  o_drop_count
);

    localparam int ACC_W = $clog2(SAMPLE_RATE + 1000);
    localparam int AGE_W = 16;
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic {IDLE, ALLOC} state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_ev_release;
    logic [NOTE_W-1:0] r_ev_note;
    logic [DUR_W-1:0]  r_ev_dur;
    logic [VEL_W-1:0]  r_ev_vel;
    logic [ACC_W-1:0]  r_acc;
    logic              r_steal;
    logic [15:0]       r_drop;

    logic [ACC_W-1:0]      w_acc_sum;
    logic                  w_ms_tick;
    logic                  w_hs;
    logic                  w_alloc;
    logic [NUM_VOICES-1:0] w_active;
    logic [AGE_W-1:0]      w_age [NUM_VOICES];
    logic                  w_free_found;
    logic [IDX_W-1:0]      w_free_idx;
    logic [IDX_W-1:0]      w_victim_idx;
    logic [AGE_W-1:0]      w_best_age;
    logic [IDX_W-1:0]      w_load_idx;
    logic                  w_note_on;
    logic                  w_note_off;
    logic                  w_do_load;
    logic                  w_steal;
    logic                  w_drop;

    // Sum never exceeds SAMPLE_RATE+999, so it fits in ACC_W bits.
    assign w_acc_sum = r_acc + ACC_W'(1000);
    assign w_ms_tick = i_sample_tick && (w_acc_sum >= ACC_W'(SAMPLE_RATE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_sample_tick) begin
            r_acc <= w_ms_tick ? (w_acc_sum - ACC_W'(SAMPLE_RATE)) : w_acc_sum;
        end
    end

    // Ready is also gated by rst_n so it reads 0 while reset is held.
    assign ev_if.ev_ready = r_ready & rst_n;
    assign w_hs           = ev_if.ev_valid & ev_if.ev_ready;
    assign w_alloc        = (r_state == ALLOC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_ev_release <= 1'b0;
            r_ev_note    <= '0;
            r_ev_dur     <= '0;
            r_ev_vel     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_state      <= ALLOC;
                        r_ready      <= 1'b0;
                        r_ev_release <= ev_if.ev_release;
                        r_ev_note    <= ev_if.ev_note;
                        r_ev_dur     <= ev_if.ev_dur_ms;
                        r_ev_vel     <= ev_if.ev_vel;
                    end
                end
                ALLOC: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!w_active[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    // Strict '>' keeps the lowest index on equal ages.
    always_comb begin
        w_victim_idx = '0;
        w_best_age   = w_age[0];
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (w_age[i] > w_best_age) begin
                w_best_age   = w_age[i];
                w_victim_idx = IDX_W'(i);
            end
        end
    end

    assign w_note_on  = w_alloc && !r_ev_release && (r_ev_dur != '0);
    assign w_note_off = w_alloc && r_ev_release;
    assign w_do_load  = w_note_on && (w_free_found || (STEAL_MODE != 0));
    assign w_load_idx = w_free_found ? w_free_idx : w_victim_idx;
    assign w_steal    = w_note_on && !w_free_found && (STEAL_MODE != 0);
    assign w_drop     = w_note_on && !w_free_found && (STEAL_MODE == 0);

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
        logic              r_active;
        logic              r_start;
        logic              r_end;
        logic [NOTE_W-1:0] r_note;
        logic [VEL_W-1:0]  r_vel;
        logic [DUR_W-1:0]  r_rem;
        logic [AGE_W-1:0]  r_age;
        logic              w_load;
        logic              w_off;
        logic              w_expire;

        assign w_load   = w_do_load && (w_load_idx == IDX_W'(gi));
        assign w_off    = w_note_off && r_active && (r_note == r_ev_note);
        assign w_expire = w_ms_tick && r_active && (r_rem == DUR_W'(1));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_active <= 1'b0;
                r_start  <= 1'b0;
                r_end    <= 1'b0;
                r_note   <= '0;
                r_vel    <= '0;
                r_rem    <= '0;
                r_age    <= '0;
            end else begin
                r_start <= w_load;
                // A load onto a busy voice is a steal and ends the old note.
                r_end   <= w_expire || w_off || (w_load && r_active);
                if (w_load) begin
                    r_active <= 1'b1;
                    r_note   <= r_ev_note;
                    r_vel    <= r_ev_vel;
                    r_rem    <= r_ev_dur;
                    r_age    <= '0;
                end else if (w_off || w_expire) begin
                    r_active <= 1'b0;
                end else if (w_ms_tick && r_active) begin
                    r_rem <= r_rem - DUR_W'(1);
                    if (r_age != '1) begin
                        r_age <= r_age + AGE_W'(1);
                    end
                end
            end
        end

        assign w_active[gi]                         = r_active;
        assign w_age[gi]                            = r_age;
        assign o_voice_active[gi]                   = r_active;
        assign o_voice_start[gi]                    = r_start;
        assign o_voice_end[gi]                      = r_end;
        assign o_voice_note[gi*NOTE_W +: NOTE_W]    = r_note;
        assign o_voice_vel[gi*VEL_W +: VEL_W]       = r_vel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_steal <= 1'b0;
            r_drop  <= '0;
        end else begin
            r_steal <= w_steal;
            if (w_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    assign o_steal_pulse = r_steal;
    assign o_drop_count  = r_drop;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: a steal-mode and a drop-mode instance share stimulus and
// are checked every cycle against a behavioural voice-pool model.
module tb_voice_allocator;
    localparam int NV = 4;
    localparam int NW = 12;
    localparam int DW = 16;
    localparam int VW = 8;
    localparam int SR = 44100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sample_tick = 1'b0;
    always #5 clk = ~clk;

    logic          tv_valid = 1'b0;
    logic          tv_rel   = 1'b0;
    logic [NW-1:0] tv_note  = '0;
    logic [DW-1:0] tv_dur   = '0;
    logic [VW-1:0] tv_vel   = '0;

    voice_allocator_if #(.NOTE_W(NW), .DUR_W(DW), .VEL_W(VW)) if1 ();
    voice_allocator_if #(.NOTE_W(NW), .DUR_W(DW), .VEL_W(VW)) if0 ();

    assign if1.ev_valid = tv_valid;  assign if0.ev_valid = tv_valid;
    assign if1.ev_release = tv_rel;  assign if0.ev_release = tv_rel;
    assign if1.ev_note = tv_note;    assign if0.ev_note = tv_note;
    assign if1.ev_dur_ms = tv_dur;   assign if0.ev_dur_ms = tv_dur;
    assign if1.ev_vel = tv_vel;      assign if0.ev_vel = tv_vel;

    logic [NV-1:0]    d_act   [2];
    logic [NV-1:0]    d_start [2];
    logic [NV-1:0]    d_end   [2];
    logic [NV*NW-1:0] d_note  [2];
    logic [NV*VW-1:0] d_vel   [2];
    logic             d_steal [2];
    logic [15:0]      d_drop  [2];

    voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW), .VEL_W(VW),
                      .SAMPLE_RATE(SR), .STEAL_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_sample_tick(sample_tick), .ev_if(if1),
        .o_voice_active(d_act[1]), .o_voice_start(d_start[1]), .o_voice_end(d_end[1]),
        .o_voice_note(d_note[1]), .o_voice_vel(d_vel[1]),
        .o_steal_pulse(d_steal[1]), .o_drop_count(d_drop[1]));

    voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW), .VEL_W(VW),
                      .SAMPLE_RATE(SR), .STEAL_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_sample_tick(sample_tick), .ev_if(if0),
        .o_voice_active(d_act[0]), .o_voice_start(d_start[0]), .o_voice_end(d_end[0]),
        .o_voice_note(d_note[0]), .o_voice_vel(d_vel[0]),
        .o_steal_pulse(d_steal[0]), .o_drop_count(d_drop[0]));

    // Behavioural model: index [m] is the steal mode of the instance.
    int     m_active [2][NV];
    int     m_note   [2][NV];
    int     m_vel    [2][NV];
    int     m_rem    [2][NV];
    int     m_age    [2][NV];
    int     m_start  [2][NV];
    int     m_end    [2][NV];
    int     m_steal  [2];
    int     m_drop   [2];
    bit     pend;
    int     p_rel, p_note, p_dur, p_vel;
    longint n_samp;

    int n_vec = 0;
    int n_bad = 0;

    // A millisecond boundary is crossed when floor(n*1000/SR) steps up.
    function automatic bit ms_cross(input longint n);
        return ((n * 1000) / SR) != (((n - 1) * 1000) / SR);
    endfunction

    function automatic int count_ms(input longint n);
        int c = 0;
        for (longint k = 1; k <= n; k++) c += ms_cross(k);
        return c;
    endfunction

    task automatic check(input string nm, input int m, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s mode%0d at %0t: got %h expected %h", nm, m, $time, a, e);
        end
    endtask

    task automatic lit(input string nm, input logic [63:0] a, input logic [63:0] e);
        check(nm, 9, a, e);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < NV; v++) begin
                m_active[m][v] = 0; m_note[m][v] = 0; m_vel[m][v] = 0;
                m_rem[m][v] = 0; m_age[m][v] = 0; m_start[m][v] = 0; m_end[m][v] = 0;
            end
            m_steal[m] = 0; m_drop[m] = 0;
        end
        pend = 0; n_samp = 0;
    endtask

    task automatic model_step();
        bit ms = 0;
        if (sample_tick) begin
            n_samp++;
            ms = ms_cross(n_samp);
        end
        for (int m = 0; m < 2; m++) begin
            int oa [NV];
            int og [NV];
            int tgt;
            for (int v = 0; v < NV; v++) begin
                oa[v] = m_active[m][v]; og[v] = m_age[m][v];
                m_start[m][v] = 0; m_end[m][v] = 0;
            end
            m_steal[m] = 0;
            if (ms) begin
                for (int v = 0; v < NV; v++) begin
                    if (oa[v] != 0) begin
                        if (m_rem[m][v] == 1) begin
                            m_active[m][v] = 0; m_end[m][v] = 1;
                        end else begin
                            m_rem[m][v]--;
                            if (m_age[m][v] < 65535) m_age[m][v]++;
                        end
                    end
                end
            end
            if (pend) begin
                if (p_rel != 0) begin
                    for (int v = 0; v < NV; v++)
                        if (oa[v] != 0 && m_note[m][v] == p_note) begin
                            m_active[m][v] = 0; m_end[m][v] = 1;
                        end
                end else if (p_dur != 0) begin
                    tgt = -1;
                    for (int v = 0; v < NV; v++) if (oa[v] == 0 && tgt < 0) tgt = v;
                    if (tgt < 0 && m == 1) begin
                        tgt = 0;
                        for (int v = 1; v < NV; v++) if (og[v] > og[tgt]) tgt = v;
                        m_end[m][tgt] = 1; m_steal[m] = 1;
                    end else if (tgt < 0) begin
                        if (m_drop[m] < 65535) m_drop[m]++;
                    end
                    if (tgt >= 0) begin
                        m_active[m][tgt] = 1; m_note[m][tgt] = p_note; m_vel[m][tgt] = p_vel;
                        m_rem[m][tgt] = p_dur; m_age[m][tgt] = 0; m_start[m][tgt] = 1;
                    end
                end
            end
        end
        if (pend) pend = 0;
        else if (tv_valid) begin
            pend = 1; p_rel = int'(tv_rel); p_note = int'(tv_note);
            p_dur = int'(tv_dur); p_vel = int'(tv_vel);
        end
    endtask

    task automatic compare();
        for (int m = 0; m < 2; m++) begin
            logic [63:0] ea, es, ee, en, ev;
            logic        rdy;
            ea = '0; es = '0; ee = '0; en = '0; ev = '0;
            for (int v = 0; v < NV; v++) begin
                ea[v] = (m_active[m][v] != 0);
                es[v] = (m_start[m][v] != 0);
                ee[v] = (m_end[m][v] != 0);
                en = en | (64'(m_note[m][v]) << (v * NW));
                ev = ev | (64'(m_vel[m][v]) << (v * VW));
            end
            rdy = (m == 1) ? if1.ev_ready : if0.ev_ready;
            check("voice_active", m, 64'(d_act[m]), ea);
            check("voice_start", m, 64'(d_start[m]), es);
            check("voice_end", m, 64'(d_end[m]), ee);
            check("voice_note", m, 64'(d_note[m]), en);
            check("voice_vel", m, 64'(d_vel[m]), ev);
            check("steal_pulse", m, 64'(d_steal[m]), 64'(m_steal[m]));
            check("drop_count", m, 64'(d_drop[m]), 64'(m_drop[m]));
            check("ev_ready", m, 64'(rdy), 64'(rst_n && !pend));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic send_ev(input int rel, input int note, input int dur, input int vel);
        int guard = 0;
        bit accepted = 0;
        tv_rel = rel[0]; tv_note = NW'(note); tv_dur = DW'(dur); tv_vel = VW'(vel);
        tv_valid = 1'b1;
        while (!accepted && guard < 20) begin
            accepted = rst_n && !pend;
            cycle();
            guard++;
        end
        if (!accepted) lit("handshake_timeout", 64'd0, 64'd1);
        tv_valid = 1'b0;
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k, ends;
        bit fell;
        model_reset();
        sample_tick = 1'b1;
        @(negedge clk);
        compare();
        lit("reset_ready", 64'(if1.ev_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        lit("ready_after_release", 64'(if1.ev_ready), 64'd1);

        // Model pins for the millisecond tick.
        lit("ms_cross_44", 64'(ms_cross(44)), 64'd0);
        lit("ms_cross_45", 64'(ms_cross(45)), 64'd1);
        lit("ms_per_44100", 64'(count_ms(44100)), 64'd1000);

        // Single short note: loaded on sample 2, third ms tick lands on sample 133.
        send_ev(0, 48, 3, 100);
        lit("start_48", 64'(d_start[1]), 64'h1);
        k = 0; ends = 0; fell = 0;
        while (!fell && k < 400) begin
            cycle();
            k++;
            ends += int'(d_end[1][0]);
            if (!d_act[1][0]) fell = 1;
        end
        lit("expire_cycle", 64'(k), 64'd131);
        repeat (3) begin
            cycle();
            ends += int'(d_end[1][0]);
        end
        lit("end_pulses", 64'(ends), 64'd1);

        // Two voices on note 50 released together; unmatched note-off does nothing.
        send_ev(0, 50, 500, 20);
        send_ev(0, 50, 500, 21);
        send_ev(1, 50, 0, 0);
        lit("off50_end", 64'(d_end[1]), 64'h3);
        lit("off50_active", 64'(d_act[1]), 64'h0);
        send_ev(1, 60, 0, 0);
        lit("off60_end", 64'(d_end[1]), 64'h0);

        // Five note-ons 1 ms apart: steal in mode 1, drop in mode 0.
        send_ev(0, 48, 500, 1);  repeat (50) cycle();
        send_ev(0, 50, 500, 2);  repeat (50) cycle();
        send_ev(0, 52, 500, 3);  repeat (50) cycle();
        send_ev(0, 53, 500, 4);  repeat (50) cycle();
        send_ev(0, 55, 500, 5);
        lit("steal_pulse", 64'(d_steal[1]), 64'd1);
        lit("steal_note0", 64'(d_note[1][NW-1:0]), 64'd55);
        lit("steal_start", 64'(d_start[1]), 64'h1);
        lit("steal_end", 64'(d_end[1]), 64'h1);
        lit("steal_drop", 64'(d_drop[1]), 64'd0);
        lit("drop_count", 64'(d_drop[0]), 64'd1);
        lit("drop_note0", 64'(d_note[0][NW-1:0]), 64'd48);
        lit("drop_no_steal", 64'(d_steal[0]), 64'd0);

        // Reset while ALLOC is pending with three voices busy.
        rst_n = 1'b0; model_reset(); #1; compare();
        @(negedge clk); rst_n = 1'b1; #1; compare();
        send_ev(0, 48, 500, 9);
        send_ev(0, 50, 500, 9);
        send_ev(0, 52, 500, 9);
        tv_rel = 1'b0; tv_note = NW'(60); tv_dur = DW'(40); tv_vel = VW'(7);
        tv_valid = 1'b1;
        cycle();
        tv_valid = 1'b0;
        rst_n = 1'b0; model_reset(); #1;
        compare();
        lit("rst_alloc_active", 64'(d_act[1]), 64'h0);
        lit("rst_alloc_note", 64'(d_note[1]), 64'h0);
        lit("rst_alloc_ready", 64'(if1.ev_ready), 64'd0);
        repeat (2) begin @(negedge clk); compare(); end
        tv_note = NW'(62); tv_dur = DW'(4); tv_valid = 1'b1;
        rst_n = 1'b1; #1;
        lit("release_ready", 64'(if1.ev_ready), 64'd1);
        cycle();
        tv_valid = 1'b0;
        cycle();
        lit("post_rst_start", 64'(d_start[1]), 64'h1);
        lit("post_rst_note0", 64'(d_note[1][NW-1:0]), 64'd62);

        // Randomised traffic with a mid-run reset.
        for (int i = 0; i < 4000; i++) begin
            sample_tick = ($urandom_range(0, 7) != 0);
            tv_valid = ($urandom_range(0, 2) == 0);
            tv_rel   = ($urandom_range(0, 9) < 3);
            tv_note  = NW'(48 + $urandom_range(0, 5));
            tv_dur   = DW'($urandom_range(0, 6));
            tv_vel   = VW'($urandom_range(0, 255));
            if (i == 2000) begin
                rst_n = 1'b0; model_reset(); #1; compare();
                @(negedge clk); compare();
                rst_n = 1'b1; #1; compare();
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 4: number of voice slots, range 1-16.
REQ-002 Parameter NOTE_W, default 12: note code width.
REQ-003 Parameter DUR_W, default 16: duration width, in ms.
REQ-004 Parameter VEL_W, default 8: velocity width.
REQ-005 Parameter SAMPLE_RATE, default 44100: sample_tick rate in Hz.
REQ-006 Parameter STEAL_MODE, default 1: 1 = steal the oldest voice when full; 0 = drop the event.
REQ-007 One clock; reset is asynchronous and active-low: clk  in  1  system clock, all state on rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 sample_tick  in  1  one-cycle strobe per audio sample.
REQ-010 ev_valid  in  1  event offered.
REQ-011 ev_ready  out  1  event accepted on the edge where ev_valid and ev_ready are both high.
REQ-012 ev_release  in  1  1 = note-off event, 0 = note-on event.
REQ-013 ev_note  in  NOTE_W  note code.
REQ-014 ev_dur_ms  in  DUR_W  note-on duration in ms.
REQ-015 ev_vel  in  VEL_W  note-on velocity.
REQ-016 voice_active  out  NUM_VOICES  per-voice busy flag.
REQ-017 voice_start  out  NUM_VOICES  one-cycle pulse when a voice is (re)loaded.
REQ-018 voice_end  out  NUM_VOICES  one-cycle pulse when a voice expires or is released.
REQ-019 voice_note  out  NUM_VOICES*NOTE_W  flattened; voice i occupies bits [i*NOTE_W +: NOTE_W].
REQ-020 voice_vel  out  NUM_VOICES*VEL_W  flattened, same packing as voice_note.
REQ-021 steal_pulse  out  1  one-cycle pulse when an active voice is stolen.
REQ-022 drop_count  out  16  saturating count of dropped note-on events.

Function
REQ-023 ms_tick generation: on each sample_tick, a phase accumulator adds 1000; when the result is at least SAMPLE_RATE, it subtracts SAMPLE_RATE and asserts an internal ms_tick for that cycle; the long-run rate is exactly 1 kHz with no rounding drift.
REQ-024 The FSM has two states, IDLE and ALLOC; ev_ready = 1 only in IDLE.
REQ-025 Handshake in IDLE registers the event and moves to ALLOC.
REQ-026 ALLOC lasts exactly one cycle, then returns to IDLE; the throughput limit is one event per 2 cycles.
REQ-027 Note-on allocation (ALLOC edge):
- Use the lowest-index voice with voice_active = 0.
- If no voice is free and STEAL_MODE = 1, take the voice with the largest age; ties go to the lowest index; steal_pulse asserts.
- If no voice is free and STEAL_MODE = 0, increment drop_count (saturating at 0xFFFF) and change no voice.
REQ-028 Loading a voice sets note, vel, remaining = ev_dur_ms, age = 0, and active = 1.
REQ-029 voice_start pulses in the cycle after the ALLOC edge: accept at edge N gives a pulse during cycle N+2.
REQ-030 A note-on with ev_dur_ms = 0 is accepted and discarded: no allocation, no drop count.
REQ-031 Note-off at the ALLOC edge clears every active voice whose note equals ev_note and pulses voice_end for each; if none match, there is no effect.
REQ-032 On ms_tick, each active voice decrements remaining and increments age (saturating).
REQ-033 A voice with remaining = 1 at an ms_tick clears active and pulses voice_end.
REQ-034 Free-voice selection uses registered voice_active from before the edge: a voice expiring on the same edge as ALLOC is not free.
REQ-035 A voice loaded on an ms_tick edge takes the load values; the decrement is suppressed.
REQ-036 A stolen voice pulses both voice_end and voice_start for its index.
REQ-037 A repeated note-on for an already-sounding note allocates a new voice (no retrigger merging).
REQ-038 voice_note and voice_vel hold their last values after a voice goes inactive.

Reset
REQ-039 Asserting rst_n low immediately clears all of the following:
- voice_active, voice_start, voice_end, steal_pulse, drop_count, voice_note, voice_vel, all remaining/age counters, and the ms accumulator.
- FSM goes to IDLE; ev_ready = 0 while in reset, and 1 in the first cycle after release.
REQ-040 Reset mid-ALLOC discards the pending event.
REQ-041 A handshake in the cycle rst_n deasserts is accepted normally.

Verification
REQ-042 NUM_VOICES = 4, one sample_tick every cycle, note-on 48 with dur 3 -> voice_start = 0001 at cycle N+2; voice_active[0] falls after exactly 3 ms_ticks (132 or 133 sample_ticks per the accumulator); voice_end[0] pulses once.
REQ-043 Accumulator over 44100 sample_ticks -> exactly 1000 ms_ticks.
REQ-044 STEAL_MODE = 1, five note-ons 48, 50, 52, 53, 55 spaced 1 ms apart, dur 500 -> the fifth steals voice 0; steal_pulse = 1; voice_note[0] = 55; drop_count = 0.
REQ-045 STEAL_MODE = 0, same stimulus as REQ-044 -> the fifth is dropped; drop_count = 1; voice 0 still holds 48.
REQ-046 Two voices playing 50, then note-off 50 -> both clear on the same edge, with voice_end pulsed for both; a note-off for 60 -> no change.
REQ-047 rst_n pulsed low while in ALLOC with 3 voices active -> all outputs 0 immediately; the pending note is never started.
